// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported, variable-latency Avalon-style bus
// between the CPU instruction port and data port. The CPU keeps its Harvard
// view (ip/dp ports plus stall) while the arbiter serialises at most one data
// access and one instruction fetch per CPU cycle onto the bus.
module mem_bus_arbiter #(
  parameter int DATA_FIRST = 1,
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ip_address,
  input  logic        read_ip,
  output logic [31:0] ip_data,
  input  logic [31:0] dp_address,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        read_dp,
  input  logic        write_dp,
  output logic [31:0] dp_data,
  output logic        stall,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        bus_error
);

  localparam int WW = $clog2(WAIT_LIMIT + 1);
  // Counter value seen on the wait cycle that would make the count reach WAIT_LIMIT.
  localparam logic [WW-1:0] LAST_WAIT = WW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_ACC  = 2'd1,
    INSTR_ACC = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t          state;
  logic [31:0]     ip_addr;
  logic [31:0]     dp_addr;
  logic [31:0]     st_data;
  logic [3:0]      st_be;
  logic            is_store;
  logic            pend_instr;
  logic            pend_data;
  logic [WW-1:0]   wait_cnt;

  logic            data_req;
  logic            take_data;
  logic            timeout;

  // Byte-offset bits never reach the bus; the bus is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, ip_address[1:0], dp_address[1:0]};

  // Request decode: which access goes first and whether this wait cycle times out.
  always_comb begin
    data_req  = read_dp | write_dp;
    take_data = data_req & ((DATA_FIRST != 0) | ~read_ip);
    timeout   = mem_waitrequest & (wait_cnt == LAST_WAIT);
  end

  // CPU stall: follows requests in IDLE, high during bus accesses, low in RELEASE and reset.
  always_comb begin
    stall = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else begin
      case (state)
        IDLE:      stall = data_req | read_ip;
        DATA_ACC:  stall = 1'b1;
        INSTR_ACC: stall = 1'b1;
        RELEASE:   stall = 1'b0;
        default:   stall = 1'b0;
      endcase
    end
  end

  // Arbitration FSM with registered bus outputs, captured read data and the sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ip_addr        <= 32'h0;
      dp_addr        <= 32'h0;
      st_data        <= 32'h0;
      st_be          <= 4'h0;
      is_store       <= 1'b0;
      pend_instr     <= 1'b0;
      pend_data      <= 1'b0;
      wait_cnt       <= {WW{1'b0}};
      ip_data        <= 32'h0;
      dp_data        <= 32'h0;
      mem_address    <= 32'h0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= 32'h0;
      mem_byteenable <= 4'h0;
      bus_error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= {WW{1'b0}};
          // Latch both sides so the second access does not depend on the CPU inputs.
          ip_addr  <= {ip_address[31:2], 2'b00};
          dp_addr  <= {dp_address[31:2], 2'b00};
          st_data  <= writedata;
          st_be    <= byteenable;
          is_store <= write_dp;
          if (take_data) begin
            pend_instr     <= read_ip;
            pend_data      <= 1'b0;
            mem_address    <= {dp_address[31:2], 2'b00};
            mem_read       <= ~write_dp;
            mem_write      <= write_dp;
            mem_writedata  <= write_dp ? writedata : 32'h0;
            mem_byteenable <= write_dp ? byteenable : 4'b1111;
            state          <= DATA_ACC;
          end else if (read_ip) begin
            pend_instr     <= 1'b0;
            pend_data      <= data_req;
            mem_address    <= {ip_address[31:2], 2'b00};
            mem_read       <= 1'b1;
            mem_write      <= 1'b0;
            mem_writedata  <= 32'h0;
            mem_byteenable <= 4'b1111;
            state          <= INSTR_ACC;
          end else begin
            state <= IDLE;
          end
        end

        DATA_ACC: begin
          if (!mem_waitrequest) begin
            wait_cnt <= {WW{1'b0}};
            if (!is_store) begin
              dp_data <= mem_readdata;
            end else begin
              dp_data <= dp_data;
            end
            if (pend_instr) begin
              pend_instr     <= 1'b0;
              mem_address    <= ip_addr;
              mem_read       <= 1'b1;
              mem_write      <= 1'b0;
              mem_writedata  <= 32'h0;
              mem_byteenable <= 4'b1111;
              state          <= INSTR_ACC;
            end else begin
              mem_read  <= 1'b0;
              mem_write <= 1'b0;
              state     <= RELEASE;
            end
          end else if (timeout) begin
            // Give up on the bus: abandon any pending access and let the CPU advance.
            bus_error  <= 1'b1;
            wait_cnt   <= {WW{1'b0}};
            pend_instr <= 1'b0;
            pend_data  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            state      <= RELEASE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        INSTR_ACC: begin
          if (!mem_waitrequest) begin
            wait_cnt <= {WW{1'b0}};
            ip_data  <= mem_readdata;
            if (pend_data) begin
              pend_data      <= 1'b0;
              mem_address    <= dp_addr;
              mem_read       <= ~is_store;
              mem_write      <= is_store;
              mem_writedata  <= is_store ? st_data : 32'h0;
              mem_byteenable <= is_store ? st_be : 4'b1111;
              state          <= DATA_ACC;
            end else begin
              mem_read  <= 1'b0;
              mem_write <= 1'b0;
              state     <= RELEASE;
            end
          end else if (timeout) begin
            bus_error  <= 1'b1;
            wait_cnt   <= {WW{1'b0}};
            pend_instr <= 1'b0;
            pend_data  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            state      <= RELEASE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        RELEASE: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
